// File: rtl/seg_pkg.sv
// Shared seven-segment definitions.
// Holds the active-high hex-to-segment table (bit 6 = segment a, bit 0 = g),
// the blank pattern and a lookup helper used by the digit decoder.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Active-high segment pattern {a,b,c,d,e,f,g} for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_HEX[hex];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to seven-segment decoder (active-high output).
// Ports:
//   hex_i  4-bit hex digit
//   seg_o  segments {a,b,c,d,e,f,g}, bit 6 = a
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern.
  always_comb begin
    seg_o = hex_to_seg(hex_i);
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for NUM_DIGITS seven-segment digits sharing one
// segment bus. A loaded value is double-buffered and only becomes visible at
// a frame boundary, so a frame never mixes old and new data. Supports per-digit
// decimal points, leading-zero blanking and per-digit blinking.
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   enable       1 = scan and drive, 0 = dark with counters frozen
//   load         one-cycle strobe capturing value/dp/blink_mask
//   value        packed hex digits, digit 0 = bits [3:0]
//   dp           decimal point request per digit
//   blink_mask   1 = digit blinks
//   lz_blank     1 = suppress leading zeros
//   seg_out      segments {a..g}, bit 6 = a (registered)
//   dp_out       decimal point of the active digit (registered)
//   an_out       one-hot digit select (registered)
//   frame_start  one-cycle pulse on the cycle the digit index wraps to 0
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
)
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      lz_blank,
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic                      frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Pin-level "off" levels after polarity is applied.
  localparam logic [6:0]            SEG_OFF = SEG_BLANK ^ {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blk_phase_q, blk_phase_d;

  // Pending and display buffers
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blink_q, disp_blink_d;

  // Registered outputs
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_start_q, frame_start_d;

  // Combinational helpers
  logic                  tick_s;
  logic                  wrap_s;
  logic                  zero_above_s;
  logic [NUM_DIGITS-1:0] lz_mask_s;
  logic [NUM_DIGITS-1:0] an_sel_s;
  logic [3:0]            cur_hex_s;
  logic                  cur_dp_s;
  logic                  cur_blink_s;
  logic                  cur_lz_s;
  logic [6:0]            dec_seg_s;

  assign tick_s = enable && (cnt_q == CNT_LAST);
  assign wrap_s = tick_s && (idx_q == IDX_LAST);

  // Refresh counter, digit index and blink phase next-state.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    blk_cnt_d   = blk_cnt_q;
    blk_phase_d = blk_phase_q;
    if (tick_s) begin
      cnt_d = '0;
      if (wrap_s) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (wrap_s) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d   = '0;
        blk_phase_d = ~blk_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end else begin
      blk_cnt_d = blk_cnt_q;
    end
  end

  // Double buffer: a load coinciding with a frame boundary bypasses pending.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blink_d = pend_blink_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blink_d = disp_blink_q;
    if (load && wrap_s) begin
      disp_val_d   = value;
      disp_dp_d    = dp;
      disp_blink_d = blink_mask;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp;
      pend_blink_d = blink_mask;
      pend_valid_d = 1'b1;
    end else if (wrap_s && pend_valid_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      disp_blink_d = pend_blink_q;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Leading-zero mask: walk down from the top digit while everything seen is zero.
  always_comb begin
    zero_above_s = 1'b1;
    lz_mask_s    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s && (disp_val_q[4*i +: 4] == 4'h0);
      lz_mask_s[i] = lz_blank && zero_above_s && (i != 0);
    end
  end

  // Select the fields of the digit currently being scanned.
  always_comb begin
    cur_hex_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blink_s = 1'b0;
    cur_lz_s    = 1'b0;
    an_sel_s    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_hex_s   = disp_val_q[4*i +: 4];
        cur_dp_s    = disp_dp_q[i];
        cur_blink_s = disp_blink_q[i];
        cur_lz_s    = lz_mask_s[i];
        an_sel_s[i] = 1'b1;
      end else begin
        an_sel_s[i] = 1'b0;
      end
    end
  end

  seg_hex_decode u_dec (
    .hex_i (cur_hex_s),
    .seg_o (dec_seg_s)
  );

  // Output next-state. A zero-blanked digit still lights its select line
  // when its decimal point is requested, with the segments left blank.
  always_comb begin
    seg_d         = SEG_OFF;
    dp_d          = DP_OFF;
    an_d          = AN_OFF;
    frame_start_d = wrap_s;
    if (!enable || (cur_blink_s && blk_phase_q)) begin
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
      an_d  = AN_OFF;
    end else if (cur_lz_s) begin
      seg_d = SEG_OFF;
      dp_d  = cur_dp_s ^ SEG_ACTIVE_LOW;
      an_d  = cur_dp_s ? (an_sel_s ^ AN_OFF) : AN_OFF;
    end else begin
      seg_d = dec_seg_s ^ {7{SEG_ACTIVE_LOW}};
      dp_d  = cur_dp_s ^ SEG_ACTIVE_LOW;
      an_d  = an_sel_s ^ AN_OFF;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      blk_cnt_q   <= '0;
      blk_phase_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      blk_cnt_q   <= blk_cnt_d;
      blk_phase_q <= blk_phase_d;
    end
  end

  // Pending and display buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blink_q <= '0;
    end else begin
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blink_q <= pend_blink_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blink_q <= disp_blink_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      an_q          <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign an_out      = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed, table-driven bench for seven_seg_scan with 4 digits, a 4-cycle
// digit slot, 2-frame blink half-period, active-high segments and selects.
module tb_seven_seg_scan;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SA = 7'b1110111, SB = 7'b0011111;
  localparam logic [6:0] SC = 7'b1001110, SD = 7'b0111101, SE = 7'b1001111, SF = 7'b1000111;
  localparam logic [6:0] SX = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset, enable, load, lz_blank;
  logic [15:0] value;
  logic [3:0]  dp, blink_mask;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        lz;
    logic [15:0] val;
    logic [3:0]  dpm;
    logic [27:0] seg;   // digit 0 in [6:0]
    logic [3:0]  dpx;
    logic [3:0]  lit;
  } vec_t;

  vec_t vecs [8];

  seven_seg_scan #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV    (4),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .value       (value),
    .dp          (dp),
    .blink_mask  (blink_mask),
    .lz_blank    (lz_blank),
    .seg_out     (seg_out),
    .dp_out      (dp_out),
    .an_out      (an_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {an,seg,dp,fs}=%b want %b", name, act, exp);
    end
  endtask

  task automatic check_cycles(input string tag, input int d, input int n,
                              input logic lit, input logic [6:0] seg, input logic dpx);
    logic [3:0] an_e;
    an_e = lit ? (4'b0001 << d) : 4'b0000;
    for (int k = 0; k < n; k++) begin
      step();
      check($sformatf("%s d%0d", tag, d), {an_out, seg_out, dp_out, 1'b0},
            {an_e, seg, dpx, 1'b0});
    end
  endtask

  task automatic check_fs(input string tag);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_start: got %b want 1", tag, frame_start);
    end
  endtask

  task automatic check_frame(input string tag, input logic [27:0] seg,
                             input logic [3:0] dpx, input logic [3:0] lit);
    for (int d = 0; d < 4; d++) begin
      check_cycles(tag, d, 4, lit[d], seg[7*d +: 7], dpx[d]);
    end
    check_fs(tag);
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    check_fs({tag, " wait"});
  endtask

  task automatic do_load(input logic lz, input logic [15:0] val,
                         input logic [3:0] dpm, input logic [3:0] blk);
    lz_blank   = lz;
    value      = val;
    dp         = dpm;
    blink_mask = blk;
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      check("reset", {an_out, seg_out, dp_out, frame_start}, 13'b0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; load = 1'b0; lz_blank = 1'b0;
    value = 16'h0000; dp = 4'b0000; blink_mask = 4'b0000;

    vecs[0] = '{1'b0, 16'h12AF, 4'b0000, {S1, S2, SA, SF}, 4'b0000, 4'b1111};
    vecs[1] = '{1'b1, 16'h0030, 4'b0000, {SX, SX, S3, S0}, 4'b0000, 4'b0011};
    vecs[2] = '{1'b1, 16'h0000, 4'b0000, {SX, SX, SX, S0}, 4'b0000, 4'b0001};
    vecs[3] = '{1'b0, 16'h0030, 4'b0000, {S0, S0, S3, S0}, 4'b0000, 4'b1111};
    vecs[4] = '{1'b1, 16'h0005, 4'b0100, {SX, SX, SX, S5}, 4'b0100, 4'b0101};
    vecs[5] = '{1'b1, 16'h1000, 4'b0000, {S1, S0, S0, S0}, 4'b0000, 4'b1111};
    vecs[6] = '{1'b0, 16'h89BC, 4'b1010, {S8, S9, SB, SC}, 4'b1010, 4'b1111};
    vecs[7] = '{1'b1, 16'h0DE0, 4'b0000, {SX, SD, SE, S0}, 4'b0000, 4'b0111};

    do_reset(2);

    // Decode, leading-zero and dp patterns, one loaded value per frame.
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].lz, vecs[i].val, vecs[i].dpm, 4'b0000);
      wait_frame($sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dpx, vecs[i].lit);
    end

    // Two loads while digit 2 is active: current frame keeps old data, last load wins.
    do_load(1'b0, 16'h4567, 4'b0000, 4'b0000);
    wait_frame("t3 old");
    check_cycles("t3 old", 0, 4, 1'b1, S7, 1'b0);
    check_cycles("t3 old", 1, 4, 1'b1, S6, 1'b0);
    value = 16'h1111; load = 1'b1;
    check_cycles("t3 old", 2, 1, 1'b1, S5, 1'b0);
    value = 16'h2222;
    check_cycles("t3 old", 2, 1, 1'b1, S5, 1'b0);
    load = 1'b0;
    check_cycles("t3 old", 2, 2, 1'b1, S5, 1'b0);
    check_cycles("t3 old", 3, 4, 1'b1, S4, 1'b0);
    check_fs("t3 boundary");
    check_frame("t3 new", {S2, S2, S2, S2}, 4'b0000, 4'b1111);

    // Pause scanning for 10 cycles while digit 2 is active.
    check_cycles("t5", 0, 4, 1'b1, S2, 1'b0);
    check_cycles("t5", 1, 4, 1'b1, S2, 1'b0);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t5 paused", {an_out, seg_out, dp_out, frame_start}, 13'b0);
    end
    enable = 1'b1;
    check_cycles("t5 resume", 2, 4, 1'b1, S2, 1'b0);
    check_cycles("t5 resume", 3, 4, 1'b1, S2, 1'b0);
    check_fs("t5 spacing");

    // Reset while digit 3 is active with a load still pending.
    do_load(1'b0, 16'h9876, 4'b1111, 4'b0000);
    for (int k = 0; k < 11; k++) step();
    do_reset(1);
    step();
    check("t6 first", {an_out, seg_out, dp_out, frame_start}, {4'b0001, S0, 1'b0, 1'b0});
    wait_frame("t6");
    check_frame("t6 zero", {S0, S0, S0, S0}, 4'b0000, 4'b1111);

    // Blink on digit 0 with its dp: lit, dark, dark, lit, lit frames after first boundary.
    do_reset(2);
    do_load(1'b0, 16'h12AF, 4'b0001, 4'b0001);
    wait_frame("t4");
    check_frame("t4 f1 lit",  {S1, S2, SA, SF}, 4'b0001, 4'b1111);
    check_frame("t4 f2 dark", {S1, S2, SA, SX}, 4'b0000, 4'b1110);
    check_frame("t4 f3 dark", {S1, S2, SA, SX}, 4'b0000, 4'b1110);
    check_frame("t4 f4 lit",  {S1, S2, SA, SF}, 4'b0001, 4'b1111);
    check_frame("t4 f5 lit",  {S1, S2, SA, SF}, 4'b0001, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
